image_buffer_fetch: RTL and testbench

- SRAM arbiter read client (R1 port) that reads one grayscale frame out of the SRAM image buffer and streams it as 8-bit pixels over ready/valid.
- It is the read-side counterpart of the image buffer writer: it consumes frames the writer packed 4 pixels per 32-bit word.
- Its output feeds downstream SIFT processing.
- It uses the same start/start_ack and done/done_ack handshake pair that the swap controller drives.

---
 rtl/image_buffer_fetch_if.sv | 28 ++
 rtl/image_buffer_fetch.sv | 157 +++++++++++++++
 tb/tb_image_buffer_fetch.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/image_buffer_fetch_if.sv
// Bundle of the image_buffer_fetch control, SRAM read and pixel stream signals.
// The fetch block owns the master view; its environment uses the slave view.
interface image_buffer_fetch_if;
   logic        start;
   logic        buf_sel;
   logic        start_ack;
   logic        done;
   logic        done_ack;
   logic [17:0] addr;
   logic        addr_valid;
   logic        addr_ready;
   logic [31:0] data;
   logic        data_valid;
   logic        data_ready;
   logic [7:0]  pixel;
   logic        pixel_valid;
   logic        pixel_ready;

   modport master (
      input  start, buf_sel, done_ack, addr_ready, data, data_valid, pixel_ready,
      output start_ack, done, addr, addr_valid, data_ready, pixel, pixel_valid
   );

   modport slave (
      output start, buf_sel, done_ack, addr_ready, data, data_valid, pixel_ready,
      input  start_ack, done, addr, addr_valid, data_ready, pixel, pixel_valid
   );
endinterface

// File: rtl/image_buffer_fetch.sv
// SRAM read client: fetches one frame of 4-pixel words and streams it as 8-bit pixels.
// Reads are credit limited so the returned-word FIFO can never overflow.
module image_buffer_fetch #(
   parameter int unsigned N_PIXEL    = 480000,
   parameter logic [17:0] BASE_ADDR0 = 18'h00000,
   parameter logic [17:0] BASE_ADDR1 = 18'h20000,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input logic                  clock,
   input logic                  reset_n,
   image_buffer_fetch_if.master bus
);

   localparam int unsigned    PtrW   = $clog2(FIFO_DEPTH);
   localparam int unsigned    CntW   = PtrW + 1;
   localparam logic [17:0]    NWords = 18'(N_PIXEL / 4);
   localparam logic [CntW-1:0] Depth = CntW'(FIFO_DEPTH);

   typedef enum logic [1:0] {StIdle, StFetch, StDone} state_e;

   state_e            state_q, state_d;
   logic [17:0]       base_q, base_d;
   logic [17:0]       issued_q, issued_d;
   logic [17:0]       popped_q, popped_d;
   logic [CntW-1:0]   outst_q, outst_d;
   logic [CntW-1:0]   count_q, count_d;
   logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [1:0]        lane_q, lane_d;
   logic              start_ack_q, start_ack_d;
   logic [31:0]       mem_q [FIFO_DEPTH];
   logic [31:0]       mem_d [FIFO_DEPTH];

   logic              fetch;
   logic [CntW-1:0]   used;
   logic              addr_valid;
   logic              issue;
   logic              push;
   logic              pixel_valid;
   logic              pop_px;
   logic              pop_word;
   logic              last;
   logic [31:0]       head;
   logic [7:0]        lane_byte;

   // Handshake qualifiers and output decode, all derived from registered state.
   always_comb begin
      fetch       = (state_q == StFetch);
      used        = outst_q + count_q;
      addr_valid  = fetch && (issued_q < NWords) && (used < Depth);
      issue       = addr_valid && bus.addr_ready;
      push        = fetch && bus.data_valid;
      pixel_valid = fetch && (count_q != '0);
      pop_px      = pixel_valid && bus.pixel_ready;
      pop_word    = pop_px && (lane_q == 2'd3);
      last        = pop_word && (popped_q == NWords - 18'd1);
      head        = mem_q[rd_ptr_q];
      lane_byte   = 8'd0;
      unique case (lane_q)
         2'd0: lane_byte = head[7:0];
         2'd1: lane_byte = head[15:8];
         2'd2: lane_byte = head[23:16];
         2'd3: lane_byte = head[31:24];
      endcase
      bus.start_ack   = start_ack_q;
      bus.done        = (state_q == StDone);
      bus.addr        = fetch ? (base_q + issued_q) : 18'd0;
      bus.addr_valid  = addr_valid;
      bus.data_ready  = fetch;
      bus.pixel_valid = pixel_valid;
      bus.pixel       = pixel_valid ? lane_byte : 8'd0;
   end

   // Next-state: frame FSM, read/return counters, FIFO and byte lane.
   always_comb begin
      state_d     = state_q;
      base_d      = base_q;
      issued_d    = issued_q;
      popped_d    = popped_q;
      outst_d     = outst_q;
      count_d     = count_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      lane_d      = lane_q;
      start_ack_d = 1'b0;
      mem_d       = mem_q;
      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               start_ack_d = 1'b1;
               base_d      = bus.buf_sel ? BASE_ADDR1 : BASE_ADDR0;
               issued_d    = '0;
               popped_d    = '0;
               outst_d     = '0;
               count_d     = '0;
               wr_ptr_d    = '0;
               rd_ptr_d    = '0;
               lane_d      = '0;
               state_d     = StFetch;
            end
         end
         StFetch: begin
            if (issue) issued_d = issued_q + 18'd1;
            // Issue and return in the same cycle cancel out.
            outst_d = outst_q + CntW'(issue) - CntW'(push);
            count_d = count_q + CntW'(push) - CntW'(pop_word);
            if (push) begin
               mem_d[wr_ptr_q] = bus.data;
               wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop_px) lane_d = lane_q + 2'd1;
            if (pop_word) begin
               rd_ptr_d = rd_ptr_q + 1'b1;
               popped_d = popped_q + 18'd1;
            end
            if (last) state_d = StDone;
         end
         StDone: begin
            if (bus.done_ack) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // State registers; reset aborts any frame in progress.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= StIdle;
         base_q      <= '0;
         issued_q    <= '0;
         popped_q    <= '0;
         outst_q     <= '0;
         count_q     <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         lane_q      <= '0;
         start_ack_q <= 1'b0;
         mem_q       <= '{default: '0};
      end else begin
         state_q     <= state_d;
         base_q      <= base_d;
         issued_q    <= issued_d;
         popped_q    <= popped_d;
         outst_q     <= outst_d;
         count_q     <= count_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         lane_q      <= lane_d;
         start_ack_q <= start_ack_d;
         mem_q       <= mem_d;
      end
   end

   // A returned word while the FIFO is full means the arbiter broke the credit protocol.
   assert property (@(posedge clock) disable iff (!reset_n) !(push && (count_q == Depth)));

endmodule

// File: tb/tb_image_buffer_fetch.sv
// Directed bench: three parameterisations share one arbiter/memory model and scoreboard.
module tb_image_buffer_fetch;

   logic clock = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock = ~clock;

   // Driven by the directed sequence
   logic start = 1'b0, buf_sel = 1'b0, done_ack = 1'b0;
   int   sel = 0;
   // Driven by the arbiter model
   logic        addr_ready = 1'b0, data_valid = 1'b0, pixel_ready = 1'b0;
   logic [31:0] data = '0;

   image_buffer_fetch_if bus0 ();
   image_buffer_fetch_if bus1 ();
   image_buffer_fetch_if bus2 ();

   image_buffer_fetch #(.N_PIXEL(16)) u_dut0 (.clock(clock), .reset_n(reset_n), .bus(bus0));
   image_buffer_fetch #(.N_PIXEL(16), .BASE_ADDR0(18'h3FFFE))
      u_dut1 (.clock(clock), .reset_n(reset_n), .bus(bus1));
   image_buffer_fetch #(.N_PIXEL(64)) u_dut2 (.clock(clock), .reset_n(reset_n), .bus(bus2));

   assign bus0.start = start && (sel == 0);
   assign bus1.start = start && (sel == 1);
   assign bus2.start = start && (sel == 2);
   assign bus0.buf_sel = buf_sel;
   assign bus1.buf_sel = buf_sel;
   assign bus2.buf_sel = buf_sel;
   assign bus0.done_ack = done_ack && (sel == 0);
   assign bus1.done_ack = done_ack && (sel == 1);
   assign bus2.done_ack = done_ack && (sel == 2);
   assign bus0.addr_ready = addr_ready && (sel == 0);
   assign bus1.addr_ready = addr_ready && (sel == 1);
   assign bus2.addr_ready = addr_ready && (sel == 2);
   assign bus0.data = data;
   assign bus1.data = data;
   assign bus2.data = data;
   assign bus0.data_valid = data_valid && (sel == 0);
   assign bus1.data_valid = data_valid && (sel == 1);
   assign bus2.data_valid = data_valid && (sel == 2);
   assign bus0.pixel_ready = pixel_ready && (sel == 0);
   assign bus1.pixel_ready = pixel_ready && (sel == 1);
   assign bus2.pixel_ready = pixel_ready && (sel == 2);

   logic        o_start_ack, o_done, o_addr_valid, o_data_ready, o_pixel_valid;
   logic [17:0] o_addr;
   logic [7:0]  o_pixel;

   // Outputs of the instance under test
   always_comb begin
      o_start_ack = bus0.start_ack;  o_done = bus0.done;  o_addr = bus0.addr;
      o_addr_valid = bus0.addr_valid;  o_data_ready = bus0.data_ready;
      o_pixel = bus0.pixel;  o_pixel_valid = bus0.pixel_valid;
      if (sel == 1) begin
         o_start_ack = bus1.start_ack;  o_done = bus1.done;  o_addr = bus1.addr;
         o_addr_valid = bus1.addr_valid;  o_data_ready = bus1.data_ready;
         o_pixel = bus1.pixel;  o_pixel_valid = bus1.pixel_valid;
      end else if (sel == 2) begin
         o_start_ack = bus2.start_ack;  o_done = bus2.done;  o_addr = bus2.addr;
         o_addr_valid = bus2.addr_valid;  o_data_ready = bus2.data_ready;
         o_pixel = bus2.pixel;  o_pixel_valid = bus2.pixel_valid;
      end
   end

   int n_cmp = 0;
   int n_fail = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Scoreboard and model state
   typedef struct {logic [17:0] a; int due;} rd_t;
   rd_t         pipe[$];
   logic [17:0] exp_addr[$];
   logic [7:0]  exp_pix[$];
   logic [17:0] cur_base = '0;
   int cyc = 0, bp_cnt = 0, n_addr = 0, n_pix = 0, words_ret = 0, ack_cnt = 0;
   int occ = 0, hold_left = 0;
   logic bp_en = 1'b0, hold_en = 1'b0;
   logic addr_stall = 1'b0, px_stall = 1'b0;
   logic [17:0] prev_addr = '0;
   logic [7:0]  prev_pixel = '0;
   logic [17:0] ea;
   logic [7:0]  ep;

   // Memory word k of a frame holds pixels 4k..4k+3, k relative to the frame base.
   function automatic logic [31:0] word_of(input logic [17:0] a);
      logic [17:0] k;
      logic [7:0]  b;
      k = a - cur_base;
      b = 8'(k << 2);
      return {b + 8'd3, b + 8'd2, b + 8'd1, b};
   endfunction

   // Arbiter model: drives next-cycle inputs, then scores the handshakes the next edge will see.
   always @(negedge clock) begin
      if (!reset_n) begin
         pipe.delete();
         exp_addr.delete();
         exp_pix.delete();
         data_valid = 1'b0;
         data = '0;
         addr_ready = 1'b0;
         pixel_ready = 1'b0;
         addr_stall = 1'b0;
         px_stall = 1'b0;
      end else begin
         cyc++;
         bp_cnt = (bp_cnt + 1) % 4;
         if (hold_en && n_addr == 2 && hold_left > 0) begin
            addr_ready = 1'b0;
            hold_left--;
         end else begin
            addr_ready = 1'b1;
         end
         pixel_ready = bp_en ? (bp_cnt == 0 || bp_cnt == 3) : 1'b1;
         if (pipe.size() > 0 && pipe[0].due <= cyc) begin
            data_valid = 1'b1;
            data = word_of(pipe[0].a);
         end else begin
            data_valid = 1'b0;
         end
         if (o_start_ack) ack_cnt++;

         if (addr_stall) begin
            check("addr_valid_hold", 32'(o_addr_valid), 32'd1);
            check("addr_hold", 32'(o_addr), 32'(prev_addr));
         end
         if (px_stall) begin
            check("pixel_valid_hold", 32'(o_pixel_valid), 32'd1);
            check("pixel_hold", 32'(o_pixel), 32'(prev_pixel));
         end

         if (data_valid && o_data_ready) begin
            occ = words_ret - n_pix / 4;
            check("fifo_room", 32'(occ < 8), 32'd1);
            void'(pipe.pop_front());
            words_ret++;
         end
         if (o_addr_valid && addr_ready) begin
            check("addr_expected", 32'(exp_addr.size() != 0), 32'd1);
            if (exp_addr.size() != 0) begin
               ea = exp_addr.pop_front();
               check("addr", 32'(o_addr), 32'(ea));
            end
            pipe.push_back('{a: o_addr, due: cyc + 2});
            n_addr++;
         end
         if (o_pixel_valid && pixel_ready) begin
            check("pixel_expected", 32'(exp_pix.size() != 0), 32'd1);
            if (exp_pix.size() != 0) begin
               ep = exp_pix.pop_front();
               check("pixel", 32'(o_pixel), 32'(ep));
            end
            n_pix++;
         end
         if (o_data_ready) check("credit", 32'(pipe.size() + words_ret - n_pix / 4 <= 8), 32'd1);

         addr_stall = o_addr_valid && !addr_ready;
         prev_addr = o_addr;
         px_stall = o_pixel_valid && !pixel_ready;
         prev_pixel = o_pixel;
      end
   end

   task automatic tick();
      @(negedge clock);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_start_ack"}, 32'(o_start_ack), 32'd0);
      check({tag, "_done"}, 32'(o_done), 32'd0);
      check({tag, "_addr"}, 32'(o_addr), 32'd0);
      check({tag, "_addr_valid"}, 32'(o_addr_valid), 32'd0);
      check({tag, "_data_ready"}, 32'(o_data_ready), 32'd0);
      check({tag, "_pixel"}, 32'(o_pixel), 32'd0);
      check({tag, "_pixel_valid"}, 32'(o_pixel_valid), 32'd0);
   endtask

   task automatic begin_frame(input int s, input logic bs, input logic [17:0] base,
                              input int npix);
      sel = s;
      cur_base = base;
      exp_addr.delete();
      exp_pix.delete();
      for (int k = 0; k < npix / 4; k++) exp_addr.push_back(base + 18'(k));
      for (int p = 0; p < npix; p++) exp_pix.push_back(8'(p));
      n_addr = 0;
      n_pix = 0;
      words_ret = 0;
      ack_cnt = 0;
      buf_sel = bs;
      start = 1'b1;
      tick();
      check("start_ack_pulse", 32'(o_start_ack), 32'd1);
      buf_sel = ~bs;
      tick();
      check("start_ack_single", 32'(o_start_ack), 32'd0);
      start = 1'b0;
   endtask

   task automatic finish_frame(input int npix);
      for (int i = 0; i < 3000 && !o_done; i++) tick();
      check("done_reached", 32'(o_done), 32'd1);
      check("addr_count", 32'(n_addr), 32'(npix / 4));
      check("pixel_count", 32'(n_pix), 32'(npix));
      check("pixels_left", 32'(exp_pix.size()), 32'd0);
      check("reads_left", 32'(pipe.size()), 32'd0);
      check("done_addr_valid", 32'(o_addr_valid), 32'd0);
      check("done_pixel_valid", 32'(o_pixel_valid), 32'd0);
      check("done_data_ready", 32'(o_data_ready), 32'd0);
      start = 1'b1;
      tick();
      tick();
      check("done_start_refused", 32'(o_start_ack), 32'd0);
      check("done_held", 32'(o_done), 32'd1);
      start = 1'b0;
      done_ack = 1'b1;
      tick();
      done_ack = 1'b0;
      check("done_cleared", 32'(o_done), 32'd0);
      tick();
      check("idle_no_ack", 32'(o_start_ack), 32'd0);
      check("ack_count", 32'(ack_cnt), 32'd1);
   endtask

   initial begin
      #2;
      check_all_zero("reset");
      tick();
      tick();
      reset_n = 1'b1;
      tick();

      // Basic frame from buffer 0
      begin_frame(0, 1'b0, 18'h00000, 16);
      finish_frame(16);

      // Buffer 1
      begin_frame(0, 1'b1, 18'h20000, 16);
      finish_frame(16);

      // Pixel backpressure 1,0,0,1 on a frame longer than the FIFO
      bp_en = 1'b1;
      begin_frame(2, 1'b0, 18'h00000, 64);
      finish_frame(64);
      bp_en = 1'b0;

      // Address stall of 20 cycles after two reads
      hold_en = 1'b1;
      hold_left = 20;
      begin_frame(0, 1'b0, 18'h00000, 16);
      finish_frame(16);
      check("hold_consumed", 32'(hold_left), 32'd0);
      hold_en = 1'b0;

      // Reset in the middle of a frame, then a clean frame
      begin_frame(0, 1'b0, 18'h00000, 16);
      for (int i = 0; i < 500 && n_pix < 7; i++) tick();
      check("reached_pixel7", 32'(n_pix >= 7), 32'd1);
      reset_n = 1'b0;
      #1;
      check_all_zero("midreset");
      tick();
      tick();
      reset_n = 1'b1;
      tick();
      tick();
      check("no_resume_addr_valid", 32'(o_addr_valid), 32'd0);
      check("no_resume_pixel_valid", 32'(o_pixel_valid), 32'd0);
      begin_frame(0, 1'b0, 18'h00000, 16);
      finish_frame(16);

      // Address wrap from 3FFFE
      begin_frame(1, 1'b0, 18'h3FFFE, 16);
      finish_frame(16);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: observed no completion, expected finish before time limit");
      $fatal(1, "watchdog");
   end

endmodule
